// File: rtl/spi_param_responder_if.sv
// SPI pin bundle between a host (master) and the parameter responder (slave).
interface spi_param_responder_if;
  logic spi_scs_in;
  logic spi_sck_in;
  logic spi_sdi_in;
  logic spi_sdo_out;
  logic spi_sdo_oe_out;

  modport master (
    output spi_scs_in, spi_sck_in, spi_sdi_in,
    input  spi_sdo_out, spi_sdo_oe_out
  );

  modport slave (
    input  spi_scs_in, spi_sck_in, spi_sdi_in,
    output spi_sdo_out, spi_sdo_oe_out
  );
endinterface

// File: rtl/spi_param_responder.sv
// SPI target holding shadow copies of servo/sweep parameters; a COMMIT write
// copies all shadows to the active outputs in a single clock cycle.
module spi_param_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] ID_VALUE    = 16'h5E12
) (
  input  logic                clk_in,
  input  logic                rst_in,
  spi_param_responder_if.slave spi,
  output logic signed [34:0]  a1_PI_out,
  output logic signed [34:0]  b0_PI_out,
  output logic signed [34:0]  b1_PI_out,
  output logic signed [34:0]  a1_PD_out,
  output logic signed [34:0]  b0_PD_out,
  output logic signed [34:0]  b1_PD_out,
  output logic signed [15:0]  sweep_min_out,
  output logic signed [15:0]  sweep_max_out,
  output logic [31:0]         sweep_stepsize_out,
  output logic                commit_out,
  output logic                frame_err_out,
  output logic [2:0]          state_out
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, FULL, OVER} state_t;

  // CS chain resets low so a frame already in progress at reset release
  // produces no falling edge until CS has first been seen high.
  logic [SYNC_STAGES-1:0] scs_sync, sck_sync, sdi_sync;
  logic scs_d, sck_d;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      scs_sync <= '0;
      sck_sync <= '0;
      sdi_sync <= '0;
      scs_d    <= 1'b0;
      sck_d    <= 1'b0;
    end else begin
      scs_sync <= {scs_sync[SYNC_STAGES-2:0], spi.spi_scs_in};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi.spi_sck_in};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi.spi_sdi_in};
      scs_d    <= scs_sync[SYNC_STAGES-1];
      sck_d    <= sck_sync[SYNC_STAGES-1];
    end
  end

  logic cs_fall, cs_rise, sck_rise, sck_fall, sdi_s;
  assign cs_fall  =  scs_d & ~scs_sync[SYNC_STAGES-1];
  assign cs_rise  = ~scs_d &  scs_sync[SYNC_STAGES-1];
  assign sck_rise = ~sck_d &  sck_sync[SYNC_STAGES-1];
  assign sck_fall =  sck_d & ~sck_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [15:0] shift, hdr, rd_word;
  logic        sdo, oe, pending, commit, ferr;
  logic [34:0] coef_sh [6];
  logic [34:0] coef_act[6];
  logic [15:0] smin_sh, smax_sh, smin_act, smax_act;
  logic [31:0] step_sh, step_act;

  // Header as it stands on the 16th rising edge, before it is registered.
  logic [14:0] rd_addr;
  logic [15:0] rd_mux;
  logic [14:0] wr_addr;
  assign rd_addr = {shift[13:0], sdi_s};
  assign wr_addr = hdr[14:0];

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < 6; k++) begin
      if (rd_addr == 15'(3*k))   rd_mux = coef_sh[k][15:0];
      if (rd_addr == 15'(3*k+1)) rd_mux = coef_sh[k][31:16];
      if (rd_addr == 15'(3*k+2)) rd_mux = {13'b0, coef_sh[k][34:32]};
    end
    case (rd_addr)
      15'h12:  rd_mux = smin_sh;
      15'h13:  rd_mux = smax_sh;
      15'h14:  rd_mux = step_sh[15:0];
      15'h15:  rd_mux = step_sh[31:16];
      15'h41:  rd_mux = {15'b0, pending};
      15'hFF:  rd_mux = ID_VALUE;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      hdr      <= '0;
      rd_word  <= '0;
      sdo      <= 1'b0;
      oe       <= 1'b0;
      pending  <= 1'b0;
      commit   <= 1'b0;
      ferr     <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        coef_sh[k]  <= '0;
        coef_act[k] <= '0;
      end
      smin_sh  <= '0;
      smax_sh  <= '0;
      step_sh  <= '0;
      smin_act <= '0;
      smax_act <= '0;
      step_act <= '0;
    end else begin
      commit <= 1'b0;
      ferr   <= 1'b0;
      if (cs_rise) begin
        state <= IDLE;
        oe    <= 1'b0;
        sdo   <= 1'b0;
        if (state == FULL && !hdr[15]) begin
          if (wr_addr == 15'h40) begin
            coef_act <= coef_sh;
            smin_act <= smin_sh;
            smax_act <= smax_sh;
            step_act <= step_sh;
            pending  <= 1'b0;
            commit   <= 1'b1;
          end else if (wr_addr <= 15'h15) begin
            pending <= 1'b1;
            for (int k = 0; k < 6; k++) begin
              if (wr_addr == 15'(3*k))   coef_sh[k][15:0]  <= shift;
              if (wr_addr == 15'(3*k+1)) coef_sh[k][31:16] <= shift;
              if (wr_addr == 15'(3*k+2)) coef_sh[k][34:32] <= shift[2:0];
            end
            case (wr_addr)
              15'h12:  smin_sh         <= shift;
              15'h13:  smax_sh         <= shift;
              15'h14:  step_sh[15:0]  <= shift;
              15'h15:  step_sh[31:16] <= shift;
              default: ;
            endcase
          end
        end else if (state == ADDR || state == DATA || state == OVER) begin
          ferr <= 1'b1;
        end
      end else if (cs_fall) begin
        state   <= ADDR;
        bit_cnt <= '0;
        oe      <= 1'b1;
        sdo     <= 1'b0;
      end else begin
        if (sck_rise) begin
          case (state)
            ADDR: begin
              shift   <= {shift[14:0], sdi_s};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd15) begin
                state   <= DATA;
                hdr     <= {shift[14:0], sdi_s};
                rd_word <= shift[14] ? rd_mux : 16'h0;
              end
            end
            DATA: begin
              shift   <= {shift[14:0], sdi_s};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd31) state <= FULL;
            end
            FULL:    state <= OVER;
            default: ;
          endcase
        end
        if (sck_fall && (state == DATA || state == FULL || state == OVER)) begin
          sdo     <= rd_word[15];
          rd_word <= {rd_word[14:0], 1'b0};
        end
      end
    end
  end

  assign spi.spi_sdo_out    = sdo;
  assign spi.spi_sdo_oe_out = oe;
  assign a1_PI_out          = coef_act[0];
  assign b0_PI_out          = coef_act[1];
  assign b1_PI_out          = coef_act[2];
  assign a1_PD_out          = coef_act[3];
  assign b0_PD_out          = coef_act[4];
  assign b1_PD_out          = coef_act[5];
  assign sweep_min_out      = smin_act;
  assign sweep_max_out      = smax_act;
  assign sweep_stepsize_out = step_act;
  assign commit_out         = commit;
  assign frame_err_out      = ferr;
  assign state_out          = state;

endmodule
